modn_counter_display: RTL

- Parametrised successor to the fixed 0-19 pause/reset counter.
- Modulo-(MAX_COUNT+1) up/down counter with an internal tick prescaler, debounced pause-toggle and clear buttons, binary-to-BCD conversion and a time-multiplexed 7-segment driver of NUM_DIGITS digits.
- Sits between board buttons and the 8-anode display; replaces the separate debounce/counting/decoder/display chain with a single configurable block.

---
 rtl/modn_counter_display.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/modn_counter_display.sv
// ============================================================================
// modn_counter_display
// ----------------------------------------------------------------------------
// Modulo-(MAX_COUNT+1) up/down counter with a tick prescaler, debounced
// pause-toggle and clear buttons, binary-to-BCD conversion and a
// time-multiplexed 7-segment driver for NUM_DIGITS digits (up to 8 anodes).
//
// Parameters:
//   MAX_COUNT   terminal count, 1 .. 10^NUM_DIGITS-1
//   NUM_DIGITS  displayed decimal digits, 1 .. 8
//   TICK_DIV    clk cycles per count step, >= 1
//   DEB_CYCLES  consecutive stable samples to accept a button level, >= 2
//   SCAN_DIV    clk cycles per displayed digit, >= 1
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-low reset
//   btn_pause   raw pause button (active-high, asynchronous)
//   btn_clear   raw clear button (active-high, asynchronous)
//   dir         0 = count up, 1 = count down (asynchronous)
//   count       current binary count
//   running     1 = counting, 0 = paused
//   wrap        single-cycle pulse on a wrap-around step
//   disp        segments a..g on bits 6..0, active-high
//   anode_ctrl  digit enables, active-low one-hot; digit 0 = units
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, digit positions above the most
//                          significant non-zero digit are blanked (disp=0)
//                          while the anode keeps scanning. Digit 0 is never
//                          blanked. Undefined: leading zeros are shown.
// ============================================================================
module modn_counter_display #(
    parameter int MAX_COUNT  = 19,
    parameter int NUM_DIGITS = 2,
    parameter int TICK_DIV   = 50_000_000,
    parameter int DEB_CYCLES = 500_000,
    parameter int SCAN_DIV   = 50_000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             btn_pause,
    input  logic                             btn_clear,
    input  logic                             dir,
    output logic [$clog2(MAX_COUNT+1)-1:0]   count,
    output logic                             running,
    output logic                             wrap,
    output logic [6:0]                       disp,
    output logic [7:0]                       anode_ctrl
);

    localparam int CW  = $clog2(MAX_COUNT + 1);
    localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW  = $clog2(DEB_CYCLES);
    localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW  = 4 * NUM_DIGITS;

    // ------------------------------------------------------------------
    // Two-flop synchronisers. Bit 0 = pause, bit 1 = clear, bit 2 = dir.
    // ------------------------------------------------------------------
    logic [2:0] sync1;
    logic [2:0] sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {dir, btn_clear, btn_pause};
            sync2 <= sync1;
        end
    end

    // ------------------------------------------------------------------
    // Debouncers for the two buttons (index 0 = pause, 1 = clear).
    // The counter runs while the synchronised input disagrees with the
    // clean level; DEB_CYCLES consecutive disagreeing samples flip it.
    // rise is a registered one-cycle pulse on each 0->1 clean flip.
    // ------------------------------------------------------------------
    logic [1:0]    clean;
    logic [1:0]    rise;
    logic [DW-1:0] deb_cnt [2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clean <= '0;
            rise  <= '0;
            for (int b = 0; b < 2; b++) begin
                deb_cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                rise[b] <= 1'b0;
                if (sync2[b] == clean[b]) begin
                    deb_cnt[b] <= '0;
                end else if (deb_cnt[b] == DW'(DEB_CYCLES - 1)) begin
                    deb_cnt[b] <= '0;
                    clean[b]   <= sync2[b];
                    rise[b]    <= sync2[b];
                end else begin
                    deb_cnt[b] <= deb_cnt[b] + DW'(1);
                end
            end
        end
    end

    logic pause_rise;
    logic clear_rise;
    logic dir_s;

    assign pause_rise = rise[0];
    assign clear_rise = rise[1];
    assign dir_s      = sync2[2];

    // ------------------------------------------------------------------
    // Run/pause state. The toggle lands one cycle after the rise pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            running <= 1'b0;
        end else if (pause_rise) begin
            running <= ~running;
        end
    end

    // ------------------------------------------------------------------
    // Prescaler and modulo counter. tick uses the pre-toggle running
    // value, so a step coinciding with a pause toggle still happens.
    // Clear has priority over a coincident tick: no step, no wrap.
    // ------------------------------------------------------------------
    logic [PW-1:0] presc;
    logic          tick;

    assign tick = running && (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
            count <= '0;
            wrap  <= 1'b0;
        end else if (clear_rise) begin
            presc <= '0;
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (tick) begin
                presc <= '0;
                if (!dir_s) begin
                    if (count == CW'(MAX_COUNT)) begin
                        count <= '0;
                        wrap  <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end else begin
                    if (count == '0) begin
                        count <= CW'(MAX_COUNT);
                        wrap  <= 1'b1;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
            end else if (running) begin
                presc <= presc + PW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Binary to BCD (shift-and-add-3), registered once.
    // count <= MAX_COUNT < 10^NUM_DIGITS, so the top digit never overflows.
    // ------------------------------------------------------------------
    function automatic logic [BW-1:0] to_bcd(input logic [CW-1:0] bin);
        logic [BW-1:0] bcd;
        bcd = '0;
        for (int i = CW - 1; i >= 0; i--) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                if (bcd[4*d +: 4] >= 4'd5) begin
                    bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
                end
            end
            bcd = {bcd[BW-2:0], bin[i]};
        end
        return bcd;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h7E;
            4'd1:    s = 7'h30;
            4'd2:    s = 7'h6D;
            4'd3:    s = 7'h79;
            4'd4:    s = 7'h33;
            4'd5:    s = 7'h5B;
            4'd6:    s = 7'h5F;
            4'd7:    s = 7'h70;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h7B;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [BW-1:0] bcd_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcd_q <= '0;
        end else begin
            bcd_q <= to_bcd(count);
        end
    end

    // ------------------------------------------------------------------
    // Digit scanning. scan_idx selects the digit shown next; disp and
    // anode_ctrl are loaded in the same register stage, so segments never
    // appear against the wrong anode.
    // ------------------------------------------------------------------
    logic [SCW-1:0] scan_cnt;
    logic [SW-1:0]  scan_idx;
    logic [3:0]     cur_digit;
    logic [6:0]     disp_next;
    logic [7:0]     anode_next;

`ifdef LEADING_ZERO_BLANK_EN
    // blank[d] is set when digit d and every digit above it are zero.
    logic [NUM_DIGITS-1:0] blank;
    logic                  seen_nz;
    logic                  cur_blank;

    always_comb begin
        blank   = '0;
        seen_nz = 1'b0;
        for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
            seen_nz  = seen_nz | (bcd_q[4*d +: 4] != 4'd0);
            blank[d] = ~seen_nz;
        end
    end
`endif

    always_comb begin
        cur_digit = 4'd0;
`ifdef LEADING_ZERO_BLANK_EN
        cur_blank = 1'b0;
`endif
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (scan_idx == SW'(d)) begin
                cur_digit = bcd_q[4*d +: 4];
`ifdef LEADING_ZERO_BLANK_EN
                cur_blank = blank[d];
`endif
            end
        end
`ifdef LEADING_ZERO_BLANK_EN
        disp_next = cur_blank ? 7'h00 : seg_of(cur_digit);
`else
        disp_next = seg_of(cur_digit);
`endif
        anode_next = 8'hFF;
        anode_next[3'(scan_idx)] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt   <= '0;
            scan_idx   <= '0;
            disp       <= 7'h00;
            anode_ctrl <= 8'hFF;
        end else begin
            disp       <= disp_next;
            anode_ctrl <= anode_next;
            if (scan_cnt == SCW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                if (scan_idx == SW'(NUM_DIGITS - 1)) begin
                    scan_idx <= '0;
                end else begin
                    scan_idx <= scan_idx + SW'(1);
                end
            end else begin
                scan_cnt <= scan_cnt + SCW'(1);
            end
        end
    end

endmodule
